// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths and line geometry.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 4;
endpackage

// File: rtl/line_adapter_line_buffer.sv
// Line-wide word store: full-line parallel load, word-indexed write,
// word-indexed read and full-line read.
module line_buffer #(
  parameter int  WORD_WIDTH     = 16,
  parameter int  WORDS_PER_LINE = 8,
  localparam int IDX_W          = $clog2(WORDS_PER_LINE),
  localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  load_en,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_word,
  output logic [LINE_WIDTH-1:0] line
);
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] words;

  // Load and word write are never requested together; load wins if they are.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (load_en)
        words[i] <= load_line[i*WORD_WIDTH +: WORD_WIDTH];
      else if (wr_en && wr_idx == IDX_W'(i))
        words[i] <= wr_word;
    end
  end

  assign rd_word = words[rd_idx];
  assign line    = words;
endmodule

// File: rtl/line_adapter.sv
// Converts one line-wide request into a WORDS_PER_LINE-beat burst on a
// word-wide memory bus; single line ack upstream.
module line_adapter #(
  parameter int  WORD_WIDTH     = $bits(lc3b_types::lc3b_word),
  parameter int  WORDS_PER_LINE = lc3b_types::WORDS_PER_LINE,
  parameter int  ADDR_WIDTH     = 16,
  localparam int LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cyc_in,
  input  logic                  stb_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] adr_in,
  input  logic [LINE_WIDTH-1:0] dat_in,
  output logic [LINE_WIDTH-1:0] dat_out,
  output logic                  ack_out,
  output logic                  mem_cyc,
  output logic                  mem_stb,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(WORD_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic                  we_q;
  logic                  req;
  logic [ADDR_WIDTH-1:0] base;
  logic                  buf_load, buf_wr;
  logic [CNT_W-1:0]      rd_idx;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [LINE_WIDTH-1:0] buf_line;
  logic                  unused_ofs;

  assign req        = cyc_in & stb_in;
  assign base       = {adr_in[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_ofs = ^adr_in[OFFSET_BITS-1:0];

  assign buf_load = !reset && state == IDLE && req && we_in;
  assign buf_wr   = !reset && state == BURST && mem_ack && !we_q;
  // Write data is registered, so the buffer is read one beat ahead.
  assign rd_idx   = (state == IDLE) ? '0 : CNT_W'(count + 1'b1);

  line_buffer #(
    .WORD_WIDTH    (WORD_WIDTH),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_buf (
    .clk      (clk),
    .load_en  (buf_load),
    .load_line(dat_in),
    .wr_en    (buf_wr),
    .wr_idx   (count),
    .wr_word  (mem_rdata),
    .rd_idx   (rd_idx),
    .rd_word  (rd_word),
    .line     (buf_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      we_q      <= 1'b0;
      ack_out   <= 1'b0;
      mem_cyc   <= 1'b0;
      mem_stb   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      dat_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_out <= 1'b0;
          if (req) begin
            we_q      <= we_in;
            count     <= '0;
            mem_cyc   <= 1'b1;
            mem_stb   <= 1'b1;
            mem_we    <= we_in;
            mem_adr   <= base;
            mem_wdata <= we_in ? dat_in[WORD_WIDTH-1:0] : rd_word;
            state     <= BURST;
          end
        end
        BURST: begin
          if (mem_ack) begin
            if (count == LAST_BEAT) begin
              mem_cyc   <= 1'b0;
              mem_stb   <= 1'b0;
              mem_we    <= 1'b0;
              mem_adr   <= '0;
              mem_wdata <= '0;
              ack_out   <= 1'b1;
              // Last word is still on mem_rdata; merge it in directly.
              if (!we_q)
                dat_out <= {mem_rdata, buf_line[LINE_WIDTH-WORD_WIDTH-1:0]};
              state     <= DONE;
            end else begin
              count     <= count + 1'b1;
              mem_adr   <= mem_adr + WORD_BYTES;
              mem_wdata <= rd_word;
            end
          end
        end
        DONE: begin
          ack_out <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_adapter.sv
// Scoreboard bench for line_adapter: word-addressed memory model plus
// expected beat/line queues checked by independent monitors.
module tb_line_adapter;
  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [15:0] wd;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cyc_in, stb_in, we_in;
  logic [15:0]  adr_in;
  logic [127:0] dat_in;
  logic [127:0] dat_out;
  logic         ack_out;
  logic         mem_cyc, mem_stb, mem_we;
  logic [15:0]  mem_adr, mem_wdata, mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int failures = 0;
  int acks_seen = 0;
  int acks_expected = 0;
  int wait_mode = 0;
  bit stray = 1'b0;

  beat_t                 beat_q[$];
  lc3b_types::lc3b_line  txn_q[$];
  lc3b_types::lc3b_line  last_fill = '0;
  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] phys_mem [logic [15:0]];

  line_adapter dut (
    .clk(clk), .reset(reset),
    .cyc_in(cyc_in), .stb_in(stb_in), .we_in(we_in),
    .adr_in(adr_in), .dat_in(dat_in),
    .dat_out(dat_out), .ack_out(ack_out),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // A line is WORDS_PER_LINE consecutive words at the aligned base.
  task automatic push_expect(input logic we, input logic [15:0] adr, input logic [127:0] line);
    logic [15:0]  base;
    logic [127:0] exp_line;
    beat_t        b;
    base = adr & 16'hFFF0;
    exp_line = last_fill;
    for (int i = 0; i < 8; i++) begin
      b.adr = base + 16'(2 * i);
      b.we  = we;
      b.wd  = line[16*i +: 16];
      beat_q.push_back(b);
      if (we) ref_mem[b.adr] = b.wd;
      else    exp_line[16*i +: 16] = ref_rd(b.adr);
    end
    if (!we) last_fill = exp_line;
    txn_q.push_back(exp_line);
    acks_expected++;
  endtask

  task automatic wait_ack(output int n);
    n = 1;
    while (!ack_out && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_txn(input logic we, input logic [15:0] adr, input logic [127:0] line, input int exp_lat);
    int n;
    push_expect(we, adr, line);
    cyc_in = 1'b1; stb_in = 1'b1; we_in = we; adr_in = adr; dat_in = line;
    @(negedge clk);
    cyc_in = 1'b0; stb_in = 1'b0;
    dat_in = {$urandom, $urandom, $urandom, $urandom};
    wait_ack(n);
    if (!ack_out) fail_now("ack_timeout");
    else if (exp_lat >= 0) check_eq("ack_latency", 128'(n), 128'(exp_lat));
    @(negedge clk);
    check_eq("ack_single_cycle", 128'(ack_out), 128'(0));
  endtask

  // Memory slave: acts just after each rising edge, checks every acked beat.
  initial begin
    bit          pending = 1'b0;
    int          wait_left = 0;
    logic [32:0] hold;
    beat_t       b;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stray) begin
        mem_ack = 1'b1;
        pending = 1'b0;
      end else if (mem_cyc && mem_stb) begin
        if (!pending) begin
          pending = 1'b1;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
          hold = {mem_we, mem_adr, mem_wdata};
        end else begin
          check_eq("mem_hold_while_waiting", 128'({mem_we, mem_adr, mem_wdata}), 128'(hold));
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          pending = 1'b0;
          if (beat_q.size() == 0) begin
            fail_now("beat_unexpected");
          end else begin
            b = beat_q.pop_front();
            check_eq("beat_adr", 128'(mem_adr), 128'(b.adr));
            check_eq("beat_we", 128'(mem_we), 128'(b.we));
            if (b.we) check_eq("beat_wdata", 128'(mem_wdata), 128'(b.wd));
          end
          if (mem_we) phys_mem[mem_adr] = mem_wdata;
          else        mem_rdata = phys_rd(mem_adr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          wait_left--;
        end
      end else begin
        mem_ack = 1'b0;
        pending = 1'b0;
      end
    end
  end

  // Upstream monitor: every line ack must match the oldest expectation.
  initial begin
    lc3b_types::lc3b_line e;
    forever begin
      @(negedge clk);
      if (ack_out) begin
        acks_seen++;
        if (txn_q.size() == 0) begin
          fail_now("ack_unexpected");
        end else begin
          e = txn_q.pop_front();
          check_eq("line_dat_out", dat_out, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line;
    int n;
    int acks_before;
    reset = 1'b1;
    cyc_in = 1'b0; stb_in = 1'b0; we_in = 1'b0; adr_in = '0; dat_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_outputs", 128'({ack_out, mem_cyc, mem_stb, mem_we, mem_adr, mem_wdata}), 128'(0));
    check_eq("reset_dat_out", dat_out, 128'(0));

    for (int i = 0; i < 8; i++) begin
      ref_mem[16'h1230 + 16'(2 * i)]  = 16'hA000 + 16'(i);
      phys_mem[16'h1230 + 16'(2 * i)] = 16'hA000 + 16'(i);
    end

    // Zero-wait fill, then the same fill with an ack every third cycle.
    wait_mode = 0;
    run_txn(1'b0, 16'h1234, {$urandom, $urandom, $urandom, $urandom}, 9);
    wait_mode = 2;
    run_txn(1'b0, 16'h1234, {$urandom, $urandom, $urandom, $urandom}, 25);

    // Write-back; dat_out must keep the previous fill.
    wait_mode = 0;
    for (int i = 0; i < 8; i++) line[16*i +: 16] = 16'h1111 * 16'(i);
    run_txn(1'b1, 16'h8000, line, 9);
    check_eq("dat_out_hold_after_write", dat_out, last_fill);

    // Reset while beat 4 of a fill is on the bus.
    push_expect(1'b0, 16'h0000, '0);
    cyc_in = 1'b1; stb_in = 1'b1; we_in = 1'b0; adr_in = 16'h0000;
    @(negedge clk);
    cyc_in = 1'b0; stb_in = 1'b0;
    n = 0;
    while (!(mem_cyc && mem_adr == 16'h0008) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("reset_beat4_not_reached");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    beat_q.delete();
    txn_q.delete();
    acks_expected--;
    last_fill = '0;
    check_eq("abort_outputs", 128'({ack_out, mem_cyc, mem_stb, mem_we, mem_adr, mem_wdata}), 128'(0));
    check_eq("abort_dat_out", dat_out, 128'(0));
    @(negedge clk);
    check_eq("abort_no_ack", 128'({ack_out, mem_cyc}), 128'(0));
    run_txn(1'b0, 16'h0040, '0, 9);

    // Stray mem_ack while idle.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stray_ack_idle", 128'({ack_out, mem_cyc, mem_stb}), 128'(0));
    end
    stray = 1'b0;
    repeat (2) @(negedge clk);

    // Fill near the top of the address space.
    run_txn(1'b0, 16'hFFF7, '0, 9);

    // Back-to-back write then read with stb held through the ack cycle.
    acks_before = acks_expected;
    line = {$urandom, $urandom, $urandom, $urandom};
    push_expect(1'b1, 16'h0200, line);
    cyc_in = 1'b1; stb_in = 1'b1; we_in = 1'b1; adr_in = 16'h0200; dat_in = line;
    @(negedge clk);
    wait_ack(n);
    if (!ack_out) fail_now("b2b_first_ack_timeout");
    we_in = 1'b0;
    push_expect(1'b0, 16'h0200, '0);
    @(negedge clk);
    check_eq("b2b_idle_after_done", 128'({ack_out, mem_cyc}), 128'(0));
    @(negedge clk);
    check_eq("b2b_second_started", 128'({mem_cyc, mem_we}), 128'(2'b10));
    cyc_in = 1'b0; stb_in = 1'b0;
    wait_ack(n);
    if (!ack_out) fail_now("b2b_second_ack_timeout");
    @(negedge clk);
    check_eq("b2b_ack_count", 128'(acks_expected - acks_before), 128'(2));

    // Randomized mix with random memory wait states.
    wait_mode = -1;
    for (int t = 0; t < 24; t++) begin
      logic [15:0] a;
      a = $urandom_range(0, 1) ? 16'h0300 + 16'(16 * $urandom_range(0, 3)) + 16'($urandom_range(0, 15))
                               : 16'($urandom);
      run_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom}, -1);
    end

    repeat (4) @(negedge clk);
    check_eq("beats_left", 128'(beat_q.size()), 128'(0));
    check_eq("lines_left", 128'(txn_q.size()), 128'(0));
    check_eq("total_acks", 128'(acks_seen), 128'(acks_expected));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
